// File: rtl/dla_pkg.sv
// Shared definitions for the DLA tile scheduler: FSM state encoding and
// the default watchdog limit.
package dla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_t;

  localparam int TIMEOUT_CYC_DEF = 65535;

endpackage

// File: rtl/dla_tile_sched.sv
// Tile scheduler: ping-pongs the PE array between two IFM buffers, counts
// completed tiles, guards each tile with a watchdog and raises a level interrupt.
module dla_tile_sched
  import dla_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_tiles,
  input  logic             cfg_abort,
  input  logic [1:0]       buf_loaded,
  input  logic             pe_done,
  input  logic             inpt_clr,
  output logic             pe_start,
  output logic             pe_buf_sel,
  output logic             pe_abort,
  output logic [1:0]       buf_free,
  output logic [1:0]       buf_valid,
  output logic             busy,
  output logic [CNT_W-1:0] tile_cnt,
  output logic             sts_err,
  output logic             inpt
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  sched_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_num_tiles, w_num_tiles_nxt;
  logic [CNT_W-1:0] r_tile_cnt, w_tile_cnt_nxt;
  logic [WD_W-1:0]  r_wdog, w_wdog_nxt;
  logic             r_cur_buf, w_cur_buf_nxt;
  logic             r_pe_start, w_pe_start_nxt;
  logic             r_pe_buf_sel, w_pe_buf_sel_nxt;
  logic             r_pe_abort, w_pe_abort_nxt;
  logic [1:0]       r_buf_free, w_buf_free_nxt;
  logic [1:0]       r_buf_valid, w_buf_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_sts_err, w_sts_err_nxt;
  logic             r_inpt, w_inpt_nxt;

  logic             w_start_ok;
  logic             w_start_zero;
  logic             w_abort;
  logic             w_buf_ready;
  logic             w_tile_done;
  logic             w_timeout;
  logic             w_inpt_set;
  logic [1:0]       w_buf_clr;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_start_ok   = (r_state == ST_IDLE) && cfg_start && (cfg_num_tiles != '0);
  assign w_start_zero = (r_state == ST_IDLE) && cfg_start && (cfg_num_tiles == '0);
  assign w_abort      = (r_state != ST_IDLE) && cfg_abort;
  assign w_buf_ready  = (r_state == ST_WAIT_BUF) && r_buf_valid[r_cur_buf] && !cfg_abort;
  // Abort outranks a tile completion arriving in the same cycle.
  assign w_tile_done  = (r_state == ST_RUN) && pe_done && !cfg_abort;
  assign w_timeout    = (r_state == ST_RUN) && !pe_done && !cfg_abort && (r_wdog == WD_LAST);
  // Compare on the incremented count so a full-scale job never wraps.
  assign w_cnt_inc    = r_tile_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_num_tiles  <= '0;
      r_tile_cnt   <= '0;
      r_wdog       <= '0;
      r_cur_buf    <= 1'b0;
      r_pe_start   <= 1'b0;
      r_pe_buf_sel <= 1'b0;
      r_pe_abort   <= 1'b0;
      r_buf_free   <= '0;
      r_buf_valid  <= '0;
      r_busy       <= 1'b0;
      r_sts_err    <= 1'b0;
      r_inpt       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_num_tiles  <= w_num_tiles_nxt;
      r_tile_cnt   <= w_tile_cnt_nxt;
      r_wdog       <= w_wdog_nxt;
      r_cur_buf    <= w_cur_buf_nxt;
      r_pe_start   <= w_pe_start_nxt;
      r_pe_buf_sel <= w_pe_buf_sel_nxt;
      r_pe_abort   <= w_pe_abort_nxt;
      r_buf_free   <= w_buf_free_nxt;
      r_buf_valid  <= w_buf_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_sts_err    <= w_sts_err_nxt;
      r_inpt       <= w_inpt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_WAIT_BUF;
      end
      ST_WAIT_BUF: begin
        if (cfg_abort)        w_state_nxt = ST_IDLE;
        else if (w_buf_ready) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_abort || w_timeout) w_state_nxt = ST_IDLE;
        else if (pe_done)           w_state_nxt = (w_cnt_inc == r_num_tiles) ? ST_DONE : ST_WAIT_BUF;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_num_tiles_nxt  = r_num_tiles;
    w_tile_cnt_nxt   = r_tile_cnt;
    w_cur_buf_nxt    = r_cur_buf;
    w_sts_err_nxt    = r_sts_err;
    w_pe_buf_sel_nxt = r_pe_buf_sel;
    w_buf_free_nxt   = '0;
    w_buf_clr        = '0;
    w_wdog_nxt       = (r_state == ST_RUN) ? r_wdog + WD_W'(1) : '0;
    w_pe_start_nxt   = w_buf_ready;
    w_pe_abort_nxt   = ((r_state == ST_RUN) && cfg_abort) || w_timeout;
    w_inpt_set       = w_start_zero || ((r_state == ST_DONE) && !cfg_abort) || w_timeout;

    if (w_start_ok) begin
      w_num_tiles_nxt = cfg_num_tiles;
      w_tile_cnt_nxt  = '0;
      w_sts_err_nxt   = 1'b0;
      w_cur_buf_nxt   = 1'b0;
    end
    if (w_buf_ready) w_pe_buf_sel_nxt = r_cur_buf;
    if (w_tile_done) begin
      w_buf_clr[r_cur_buf]      = 1'b1;
      w_buf_free_nxt[r_cur_buf] = 1'b1;
      w_tile_cnt_nxt            = w_cnt_inc;
      w_cur_buf_nxt             = ~r_cur_buf;
    end
    if (w_abort || w_timeout) w_buf_clr = 2'b11;
    if (w_timeout) w_sts_err_nxt = 1'b1;

    // A fresh load always beats a same-cycle clear; likewise for the interrupt.
    w_buf_valid_nxt = (r_buf_valid & ~w_buf_clr) | buf_loaded;
    w_inpt_nxt      = w_inpt_set | (r_inpt & ~inpt_clr);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  assign pe_start   = r_pe_start;
  assign pe_buf_sel = r_pe_buf_sel;
  assign pe_abort   = r_pe_abort;
  assign buf_free   = r_buf_free;
  assign buf_valid  = r_buf_valid;
  assign busy       = r_busy;
  assign tile_cnt   = r_tile_cnt;
  assign sts_err    = r_sts_err;
  assign inpt       = r_inpt;

endmodule

// File: tb/tb_dla_tile_sched.sv
// Bench for dla_tile_sched: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a job-level model.
module tb_dla_tile_sched;

  localparam int CNT_W = 4;
  localparam int TO    = 8;

  logic             clk           = 1'b0;
  logic             rst           = 1'b0;
  logic             cfg_start     = 1'b0;
  logic [CNT_W-1:0] cfg_num_tiles = '0;
  logic             cfg_abort     = 1'b0;
  logic [1:0]       buf_loaded    = '0;
  logic             pe_done       = 1'b0;
  logic             inpt_clr      = 1'b0;
  logic             pe_start;
  logic             pe_buf_sel;
  logic             pe_abort;
  logic [1:0]       buf_free;
  logic [1:0]       buf_valid;
  logic             busy;
  logic [CNT_W-1:0] tile_cnt;
  logic             sts_err;
  logic             inpt;

  int n_cmp = 0;
  int n_bad = 0;

  logic       q_sel[$];
  logic [1:0] q_free[$];

  dla_tile_sched #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_num_tiles(cfg_num_tiles),
    .cfg_abort    (cfg_abort),
    .buf_loaded   (buf_loaded),
    .pe_done      (pe_done),
    .inpt_clr     (inpt_clr),
    .pe_start     (pe_start),
    .pe_buf_sel   (pe_buf_sel),
    .pe_abort     (pe_abort),
    .buf_free     (buf_free),
    .buf_valid    (buf_valid),
    .busy         (busy),
    .tile_cnt     (tile_cnt),
    .sts_err      (sts_err),
    .inpt         (inpt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (job/phase view) ----------------
  logic             m_busy = 1'b0;
  logic             m_run  = 1'b0;
  logic             m_fin  = 1'b0;
  logic             m_next = 1'b0;
  logic [CNT_W-1:0] m_target = '0;
  int               m_age  = 0;
  logic [1:0]       m_clr  = '0;
  logic             m_irq  = 1'b0;
  logic             e_pe_start = 1'b0, e_pe_buf_sel = 1'b0, e_pe_abort = 1'b0;
  logic             e_busy = 1'b0, e_sts_err = 1'b0, e_inpt = 1'b0;
  logic [1:0]       e_buf_free = '0, e_buf_valid = '0;
  logic [CNT_W-1:0] e_tile_cnt = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_run = 1'b0; m_fin = 1'b0; m_next = 1'b0; m_target = '0; m_age = 0;
      e_pe_start = 1'b0; e_pe_buf_sel = 1'b0; e_pe_abort = 1'b0; e_buf_free = '0;
      e_buf_valid = '0; e_busy = 1'b0; e_tile_cnt = '0; e_sts_err = 1'b0; e_inpt = 1'b0;
    end else begin
      m_clr = '0; m_irq = 1'b0;
      e_pe_start = 1'b0; e_pe_abort = 1'b0; e_buf_free = '0;
      if (!m_busy) begin
        if (cfg_start && cfg_num_tiles == '0) m_irq = 1'b1;
        else if (cfg_start) begin
          m_busy = 1'b1; m_target = cfg_num_tiles; e_tile_cnt = '0; e_sts_err = 1'b0; m_next = 1'b0;
        end
      end else if (cfg_abort) begin
        e_pe_abort = m_run; m_busy = 1'b0; m_run = 1'b0; m_fin = 1'b0; m_clr = 2'b11;
      end else if (m_fin) begin
        m_irq = 1'b1; m_busy = 1'b0; m_fin = 1'b0;
      end else if (m_run) begin
        if (pe_done) begin
          m_clr[m_next] = 1'b1; e_buf_free[m_next] = 1'b1;
          e_tile_cnt = e_tile_cnt + CNT_W'(1);
          m_next = ~m_next; m_run = 1'b0;
          m_fin = (e_tile_cnt == m_target);
        end else begin
          m_age++;
          if (m_age >= TO) begin
            e_sts_err = 1'b1; e_pe_abort = 1'b1; m_irq = 1'b1; m_clr = 2'b11;
            m_busy = 1'b0; m_run = 1'b0;
          end
        end
      end else if (e_buf_valid[m_next]) begin
        e_pe_start = 1'b1; e_pe_buf_sel = m_next; m_run = 1'b1; m_age = 0;
      end
      e_buf_valid = (e_buf_valid & ~m_clr) | buf_loaded;
      e_inpt      = m_irq | (e_inpt & ~inpt_clr);
      e_busy      = m_busy;
    end
  end

  always @(negedge clk) begin
    chk("pe_start",   32'(pe_start),   32'(e_pe_start));
    chk("pe_buf_sel", 32'(pe_buf_sel), 32'(e_pe_buf_sel));
    chk("pe_abort",   32'(pe_abort),   32'(e_pe_abort));
    chk("buf_free",   32'(buf_free),   32'(e_buf_free));
    chk("buf_valid",  32'(buf_valid),  32'(e_buf_valid));
    chk("busy",       32'(busy),       32'(e_busy));
    chk("tile_cnt",   32'(tile_cnt),   32'(e_tile_cnt));
    chk("sts_err",    32'(sts_err),    32'(e_sts_err));
    chk("inpt",       32'(inpt),       32'(e_inpt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    cfg_start = 1'b0; cfg_abort = 1'b0; buf_loaded = '0; pe_done = 1'b0; inpt_clr = 1'b0;
  endtask

  task automatic wait_pe_start(input string name, input int bound);
    int c;
    c = 0;
    while (pe_start !== 1'b1 && c < bound) begin
      tick();
      c++;
    end
    chk(name, 32'(pe_start), 32'd1);
  endtask

  // Acts as CPU and PE: refills each freed buffer, answers pe_start after lat cycles.
  task automatic run_job(input logic [CNT_W-1:0] n, input int lat, input int bound);
    int cd;
    cd = 0;
    q_sel.delete();
    q_free.delete();
    cfg_start = 1'b1; cfg_num_tiles = n;
    tick();
    for (int c = 0; c < bound; c++) begin
      if (!busy) break;
      if (pe_start) begin q_sel.push_back(pe_buf_sel); cd = lat; end
      if (buf_free != 2'b00) begin q_free.push_back(buf_free); buf_loaded = buf_free; end
      if (cd > 0) begin cd--; if (cd == 0) pe_done = 1'b1; end
      tick();
    end
    chk("job_ended", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({pe_start, pe_buf_sel, pe_abort, buf_free, buf_valid, busy, tile_cnt, sts_err, inpt});
  endfunction

  initial begin
    int pd_pct;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b1;
    tick();

    // zero-tile job: immediate interrupt, never busy
    cfg_start = 1'b1; cfg_num_tiles = '0;
    tick();
    chk("zero_inpt", 32'(inpt), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_busy2", 32'(busy), 32'd0);
    inpt_clr = 1'b1;
    tick();
    chk("zero_clr", 32'(inpt), 32'd0);

    // no buffers loaded: held waiting
    cfg_start = 1'b1; cfg_num_tiles = CNT_W'(2);
    tick();
    chk("wait_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("wait_no_start", 32'(pe_start), 32'd0);
      tick();
    end
    buf_loaded = 2'b01;
    tick();
    chk("wait_valid", 32'(buf_valid), 32'd1);
    chk("wait_start_early", 32'(pe_start), 32'd0);
    tick();
    chk("wait_start", 32'(pe_start), 32'd1);
    chk("wait_sel", 32'(pe_buf_sel), 32'd0);

    // abort coincident with pe_done
    pe_done = 1'b1; cfg_abort = 1'b1;
    tick();
    chk("abrt_cnt", 32'(tile_cnt), 32'd0);
    chk("abrt_pe_abort", 32'(pe_abort), 32'd1);
    chk("abrt_valid", 32'(buf_valid), 32'd0);
    chk("abrt_free", 32'(buf_free), 32'd0);
    chk("abrt_inpt", 32'(inpt), 32'd0);
    chk("abrt_busy", 32'(busy), 32'd0);

    // three-tile ping-pong job with preloaded buffers
    buf_loaded = 2'b11;
    tick();
    run_job(CNT_W'(3), 5, 200);
    chk("pp_nstart", q_sel.size(), 32'd3);
    if (q_sel.size() == 3) chk("pp_sel", 32'({q_sel[0], q_sel[1], q_sel[2]}), 32'h2);
    chk("pp_nfree", q_free.size(), 32'd3);
    if (q_free.size() == 3) chk("pp_free", 32'({q_free[0], q_free[1], q_free[2]}), 32'h19);
    chk("pp_cnt", 32'(tile_cnt), 32'd3);
    chk("pp_inpt", 32'(inpt), 32'd1);

    // watchdog
    inpt_clr = 1'b1; buf_loaded = 2'b11;
    tick();
    cfg_start = 1'b1; cfg_num_tiles = CNT_W'(1);
    tick();
    wait_pe_start("wd_start", 20);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("wd_no_abort_early", 32'(pe_abort), 32'd0);
    end
    tick();
    chk("wd_abort", 32'(pe_abort), 32'd1);
    chk("wd_err", 32'(sts_err), 32'd1);
    chk("wd_inpt", 32'(inpt), 32'd1);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_valid", 32'(buf_valid), 32'd0);

    // asynchronous reset during RUN, then a normal job
    inpt_clr = 1'b1; buf_loaded = 2'b11;
    tick();
    cfg_start = 1'b1; cfg_num_tiles = CNT_W'(2);
    tick();
    chk("rst_err_cleared", 32'(sts_err), 32'd0);
    wait_pe_start("rst_start", 20);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1 chk("rst_async_outs", all_outs(), 32'd0);
    tick();
    tick();
    chk("rst_hold_outs", all_outs(), 32'd0);
    rst = 1'b1;
    buf_loaded = 2'b11;
    tick();
    run_job(CNT_W'(2), 3, 100);
    chk("post_rst_cnt", 32'(tile_cnt), 32'd2);
    if (q_sel.size() == 2) chk("post_rst_sel", 32'({q_sel[0], q_sel[1]}), 32'h1);
    chk("post_rst_inpt", 32'(inpt), 32'd1);

    // full-scale tile count
    inpt_clr = 1'b1; buf_loaded = 2'b11;
    tick();
    run_job(CNT_W'(15), 1, 300);
    chk("max_cnt", 32'(tile_cnt), 32'd15);
    chk("max_inpt", 32'(inpt), 32'd1);

    // randomized traffic
    pd_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) pd_pct = int'($urandom_range(5, 40));
      if (c == 1500) begin
        #1 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
      end
      cfg_start     = ($urandom_range(0, 99) < 6);
      cfg_num_tiles = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      if ($urandom_range(0, 19) == 0) cfg_num_tiles = '1;
      cfg_abort     = ($urandom_range(0, 199) == 0);
      buf_loaded    = {($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 12)};
      pe_done       = ($urandom_range(0, 99) < pd_pct);
      inpt_clr      = ($urandom_range(0, 99) < 5);
      tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
